// File: rtl/vc_link_tx.sv
// vc_link_tx: virtual-channel link transmitter with wormhole lock and a one-slot registered output stage
// Build option RAVENOC_VC_RR_ARB_EN: round-robin arbitration in IDLE; undefined gives fixed priority (highest VC wins)
// Ports: clk, arst (async active-high); vc_valid_i/vc_fdata_i/vc_ready_o per-VC source handshake (VC v in slice v);
//        fdata_o/vc_id_o/valid_o registered link flit; ready_i per-VC readiness of the far-end buffers
module vc_link_tx #(
    parameter int N_VIRT_CHN = 3,
    parameter int FLIT_WIDTH = 34
) (
    input  logic                             clk,
    input  logic                             arst,
    input  logic [N_VIRT_CHN-1:0]            vc_valid_i,
    input  logic [N_VIRT_CHN*FLIT_WIDTH-1:0] vc_fdata_i,
    output logic [N_VIRT_CHN-1:0]            vc_ready_o,
    output logic [FLIT_WIDTH-1:0]            fdata_o,
    output logic [1:0]                       vc_id_o,
    output logic                             valid_o,
    input  logic [N_VIRT_CHN-1:0]            ready_i
);
    localparam int PW = $clog2(N_VIRT_CHN);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_nx;
    logic [PW-1:0] lock_vc, lock_vc_nx, gnt_idx;
    logic [N_VIRT_CHN-1:0] elig, cand;
    logic [3:0] rdy_ext;
    logic [FLIT_WIDTH-1:0] sel;
    logic load_en, acc, is_head, is_tail;
    // widened so vc_id_o can index it for any channel count
    assign rdy_ext = 4'(ready_i);
    assign load_en = !valid_o || rdy_ext[vc_id_o];
    assign cand = vc_valid_i & elig;
    assign acc = |cand && load_en;
    assign sel = vc_fdata_i[int'(gnt_idx)*FLIT_WIDTH +: FLIT_WIDTH];
    assign is_head = sel[FLIT_WIDTH-1:FLIT_WIDTH-2] == 2'b00;
    assign is_tail = sel[FLIT_WIDTH-1:FLIT_WIDTH-2] == 2'b11;
    always_comb begin
        vc_ready_o = '0;
        vc_ready_o[gnt_idx] = acc && !arst;
    end
`ifdef RAVENOC_VC_RR_ARB_EN
    logic [PW-1:0] ptr;
    always_ff @(posedge clk or posedge arst)
        if (arst) ptr <= '0;
        else if (acc && is_tail) ptr <= (int'(gnt_idx) == N_VIRT_CHN-1) ? '0 : gnt_idx + 1'b1;
    // descending scan so the candidate closest above ptr is the last (winning) assignment
    always_comb begin
        gnt_idx = '0;
        for (int i = N_VIRT_CHN-1; i >= 0; i--)
            if (cand[(int'(ptr)+i) % N_VIRT_CHN]) gnt_idx = PW'((int'(ptr)+i) % N_VIRT_CHN);
    end
`else
    always_comb begin
        gnt_idx = '0;
        for (int v = 0; v < N_VIRT_CHN; v++)
            if (cand[v]) gnt_idx = PW'(v);
    end
`endif
    always_ff @(posedge clk or posedge arst)
        if (arst) begin
            state <= IDLE;
            lock_vc <= '0;
        end else begin
            state <= state_nx;
            lock_vc <= lock_vc_nx;
        end
    // while locked only lock_vc can be granted, so any accepted tail belongs to it
    always_comb begin
        state_nx = state;
        lock_vc_nx = lock_vc;
        if (acc && state == IDLE && is_head) begin
            state_nx = LOCKED;
            lock_vc_nx = gnt_idx;
        end else if (acc && state == LOCKED && is_tail) begin
            state_nx = IDLE;
        end
    end
    always_comb begin
        elig = (state == LOCKED) ? '0 : '1;
        if (state == LOCKED) elig[lock_vc] = 1'b1;
    end
    always_ff @(posedge clk or posedge arst)
        if (arst) begin
            valid_o <= 1'b0;
            fdata_o <= '0;
            vc_id_o <= '0;
        end else if (load_en) begin
            valid_o <= acc;
            if (acc) begin
                fdata_o <= sel;
                vc_id_o <= 2'(gnt_idx);
            end
        end
endmodule

// File: doc/vc_link_tx.md
VC_LINK_TX -- requirements
Module: vc_link_tx

Interface
- REQ-001: Parameter N_VIRT_CHN, default 3; number of virtual channels, range 2..4.
- REQ-002: Parameter FLIT_WIDTH, default 34; flit width, with type field at [FLIT_WIDTH-1:FLIT_WIDTH-2].
- REQ-003: clk  input  1  single clock, all state on rising edge.
- REQ-004: arst  input  1  reset, asynchronous, active-high.
- REQ-005: vc_valid_i  input  N_VIRT_CHN  per-VC source has a flit.
- REQ-006: vc_fdata_i  input  N_VIRT_CHN*FLIT_WIDTH  per-VC flits; VC v occupies slice v.
- REQ-007: vc_ready_o  output  N_VIRT_CHN  per-VC flit accepted this cycle.
- REQ-008: fdata_o  output  FLIT_WIDTH  link flit, registered.
- REQ-009: vc_id_o  output  2  VC of fdata_o, registered.
- REQ-010: valid_o  output  1  link flit valid, registered.
- REQ-011: ready_i  input  N_VIRT_CHN  per-VC ready from the far-end VC buffers.

Function
- REQ-012: Flit type SHALL be 2'b00 head, 2'b01 body, 2'b10 body, 2'b11 tail.
- REQ-013: Output stage SHALL be one register slot; it is free when valid_o=0 or ready_i[vc_id_o]=1 (load_en).
- REQ-014: Link transfer SHALL occur when valid_o=1 and ready_i[vc_id_o]=1; a blocked VC stalls the whole link (no bypass).
- REQ-015: Arbiter SHALL select at most one VC per cycle, combinationally from vc_valid_i, lock state and priority state.
- REQ-016: vc_ready_o[v] SHALL be 1 only when v is granted and load_en=1; at most one bit is set per cycle.
- REQ-017: On a vc_ready_o[v] handshake, the output register SHALL load vc_fdata_i slice v, vc_id_o=v, valid_o=1 at the next edge; latency 1 cycle.
- REQ-018: When load_en=1 and no VC is granted, valid_o SHALL clear at the next edge.
- REQ-019: Simultaneous link transfer and new load SHALL both complete in the same cycle; sustained throughput is 1 flit/cycle.
- REQ-020: Lock FSM states are IDLE and LOCKED(v).
- REQ-021: IDLE to LOCKED(v): a head flit of VC v is accepted.
- REQ-022: LOCKED(v) to IDLE: a tail flit of VC v is accepted.
- REQ-023: In LOCKED(v), only VC v SHALL be eligible; other VCs' vc_ready_o stay 0.
- REQ-024: In IDLE, a non-head flit offered on any VC SHALL be accepted and forwarded without changing lock state; no error is flagged.
- REQ-025: A head flit accepted while LOCKED(v) on the same VC SHALL be forwarded and keep LOCKED(v).
- REQ-026: Priority pointer (log2 N_VIRT_CHN bits) SHALL advance to (winner+1) mod N_VIRT_CHN on every tail acceptance; it wraps from N_VIRT_CHN-1 to 0.
- REQ-027: vc_id_o SHALL be zero-extended to 2 bits.

Reset
- REQ-028: arst=1 SHALL asynchronously force valid_o=0, fdata_o=0, vc_id_o=0, lock=IDLE, pointer=0.
- REQ-029: vc_ready_o SHALL be 0 while arst=1.
- REQ-030: Reset mid-packet SHALL discard the held flit and lock; no flit is emitted until a new handshake after release.

Configuration
- REQ-031: Macro RAVENOC_VC_RR_ARB_EN defined: in IDLE, the grant is the first valid VC searching upward from the pointer, with wrap.
- REQ-032: Macro undefined: in IDLE, fixed priority applies (highest vc_id valid wins); pointer logic is removed and its state is unused.
- REQ-033: Lock behaviour SHALL be identical in both builds.

Verification
- REQ-034: Reset release, VC0 offers head 0x0_0400_0000 with ready_i=all-1 -> vc_ready_o=3'b001 that cycle; next cycle valid_o=1, vc_id_o=0, fdata_o=0x0_0400_0000.
- REQ-035: VC1 sends head/body/tail while VC2 offers a head -> VC2 vc_ready_o=0 until VC1 tail is accepted; VC2 is granted the following cycle.
- REQ-036: ready_i[1]=0 with valid_o=1, vc_id_o=1 for 5 cycles -> fdata_o stable and all vc_ready_o=0; on ready_i[1]=1, transfer completes and the next flit is loaded in the same cycle.
- REQ-037: All 3 VCs offer single-flit tail-type packets continuously (RR build) -> grants 0,1,2,0; fixed-priority build -> VC2 always wins.
- REQ-038: arst pulsed mid-packet while LOCKED(1) -> valid_o=0 immediately; after release, a VC0 head is granted.
- REQ-039: Back-to-back 8-flit packet with ready_i=all-1 -> 8 consecutive valid_o cycles, no bubbles.
